ddr_setup_readback_256: RTL

Avalon-MM read master that fetches a block of 256-bit lines from DDR (the setup region written by the DDR setup path) and streams them out as 32-bit words with a valid/ready handshake. It sits beside the setup writer on the `clk` domain. Its consumers are the packet generator and PCIe readback, which need the stored header template as a word stream.

---
 rtl/ddr_setup_pkg.sv | 21 ++
 rtl/ddr_line_unpacker.sv | 73 +++++++
 rtl/ddr_setup_readback_256.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ddr_setup_pkg.sv
// Shared types and sizes for the DDR setup-region readback path.
//   readback_state_t : readback FSM states
//   WORDS_PER_LINE / WORD_W / LINE_W : line-to-word geometry
//   DDR_ADDR_W : Avalon word-address width
package ddr_setup_pkg;

  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LINE_W         = 256;
  localparam int unsigned DDR_ADDR_W     = 25;
  localparam int unsigned IDX_W          = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_UNPACK,
    ST_FINISH
  } readback_state_t;

endpackage

// File: rtl/ddr_line_unpacker.sv
// Holds one 256-bit line and presents it as eight 32-bit words, word 0 first.
//   load/line_in    : capture a new line and start at word 0
//   last_line       : current line is the final line of the block
//   word_*          : valid/ready word stream (all registered)
//   line_done_c     : word 7 is being accepted this cycle
module ddr_line_unpacker import ddr_setup_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LINE_W-1:0] line_in,
  input  logic              last_line,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              word_last,
  output logic              line_done_c
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  logic [LINE_W-1:0] line_q, line_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign line_done_c = valid_q & word_ready & (idx_q == LAST_IDX);

  // Word sequencing; data only advances on a handshake so it holds while stalled.
  always_comb begin
    line_d  = line_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      line_d  = line_in;
      idx_d   = '0;
      valid_d = 1'b1;
      data_d  = line_in[WORD_W-1:0];
    end else if (valid_q && word_ready) begin
      if (idx_q == LAST_IDX) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        data_d = line_q[idx_d*WORD_W +: WORD_W];
      end
    end
    // last_line is stable for the whole line, so the flag can be precomputed.
    last_d = valid_d & last_line & (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      line_q  <= line_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign word_data  = data_q;
  assign word_valid = valid_q;
  assign word_last  = last_q;

endmodule

// File: rtl/ddr_setup_readback_256.sv
// Avalon-MM read master: fetches num_lines 256-bit lines from base_addr and
// streams them out as 32-bit words.
//   start/base_addr/num_lines : readback request (sampled when idle)
//   busy/done/error           : status; done and error are one-cycle pulses
//   amm_*                     : single-beat Avalon-MM read master
//   word_*                    : 32-bit valid/ready output stream
module ddr_setup_readback_256 import ddr_setup_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_W         = DDR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_lines,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] amm_addr,
  output logic              amm_read,
  output logic [6:0]        amm_burstcount,
  output logic [31:0]       amm_byteenable,
  input  logic [LINE_W-1:0] amm_readdata,
  input  logic              amm_readdatavalid,
  input  logic              amm_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  readback_state_t   state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              amm_read_q, amm_read_d;
  logic [ADDR_W-1:0] amm_addr_q, amm_addr_d;
  logic [7:0]        lines_left_q, lines_left_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              load_c, line_done_c, tmo_expired_c, more_lines_c;

  assign tmo_expired_c = (tmo_q == TMO_LAST);
  assign more_lines_c  = (lines_left_q > 8'd1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = (num_lines == 8'd0) ? ST_FINISH : ST_REQ;
      ST_REQ:    if (amm_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (amm_readdatavalid)  state_d = ST_UNPACK;
        else if (tmo_expired_c) state_d = ST_IDLE;
      end
      ST_UNPACK: if (line_done_c) state_d = more_lines_c ? ST_REQ : ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; done is raised on entry to FINISH so it
  // lands the cycle after the final word handshake.
  always_comb begin
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    amm_read_d   = amm_read_q;
    amm_addr_d   = amm_addr_q;
    lines_left_d = lines_left_q;
    tmo_d        = tmo_q;
    load_c       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_lines == 8'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d       = 1'b1;
            amm_read_d   = 1'b1;
            amm_addr_d   = base_addr;
            lines_left_d = num_lines;
          end
        end
      end
      ST_REQ: begin
        if (amm_ready) begin
          amm_read_d = 1'b0;
          tmo_d      = '0;
        end
      end
      ST_WAIT: begin
        if (amm_readdatavalid) begin
          load_c = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_expired_c) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ST_UNPACK: begin
        if (line_done_c) begin
          if (more_lines_c) begin
            lines_left_d = lines_left_q - 8'd1;
            amm_addr_d   = amm_addr_q + ADDR_W'(1);
            amm_read_d   = 1'b1;
          end else begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      ST_FINISH: busy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      amm_read_q   <= 1'b0;
      amm_addr_q   <= '0;
      lines_left_q <= '0;
      tmo_q        <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      amm_read_q   <= amm_read_d;
      amm_addr_q   <= amm_addr_d;
      lines_left_q <= lines_left_d;
      tmo_q        <= tmo_d;
    end
  end

  ddr_line_unpacker u_unpacker (
    .clk         (clk),
    .reset       (reset),
    .load        (load_c),
    .line_in     (amm_readdata),
    .last_line   (lines_left_q == 8'd1),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_last   (word_last),
    .line_done_c (line_done_c)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign amm_read       = amm_read_q;
  assign amm_addr       = amm_addr_q;
  assign amm_burstcount = 7'd1;
  assign amm_byteenable = '1;

endmodule
